// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and transmit feeder FSM states.
// Ports: none (package only).
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo_8.sv
// Byte-wide synchronous FIFO with level tracking and flush.
// Ports: clk, rst, flush, push, pop, wr_data -> rd_data (head), level, full, empty.
module sync_fifo_8
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BYTE_W-1:0]          wr_data,
    output logic [BYTE_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage has no reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!push && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bus-side bytes and issues them to uarttx via tx_start/tx_byte/tx_ready.
// Ports: wr_en/wr_data/flush/ovf_clr in; full/empty/level/overflow/busy status; tx_* handshake.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              busy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_byte,
    input  logic              tx_ready
);

    tx_state_e         state;
    tx_state_e         state_d;
    logic              start_d;
    logic [BYTE_W-1:0] byte_d;
    logic [BYTE_W-1:0] head;
    logic              push;
    logic              pop;
    logic              drop;

    // full is the start-of-cycle value, so a same-cycle pop never makes room.
    assign push = wr_en && !full && !flush;
    assign drop = wr_en && full && !flush;

    sync_fifo_8 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_byte  <= '0;
        end else begin
            state    <= state_d;
            tx_start <= start_d;
            tx_byte  <= byte_d;
        end
    end

    // tx_start is registered: uarttx drops tx_ready while tx_start is high.
    always_comb begin
        state_d = state;
        start_d = 1'b0;
        byte_d  = tx_byte;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty && tx_ready && !flush) begin
                    pop     = 1'b1;
                    byte_d  = head;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign busy = !empty || (state != S_IDLE) || !tx_ready;

endmodule
